// File: rtl/soc_bus_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// soc_bus_arbiter_if
// Bundles the three master request ports (m0 = JTAG debug, m1 = core data,
// m2 = core instruction fetch) and the shared slave memory port.
//   mN_req_i/addr_i/we_i/wdata_i : master request payload, held until gnt
//   mN_gnt_o                     : request accepted, payload latched
//   mN_rvalid_o/rdata_o/err_o    : transaction completion
//   s_req_o/addr_o/we_o/wdata_o  : request towards the shared slave
//   s_gnt_i/rvalid_i/rdata_i     : slave acceptance and response
// Modports:
//   slave  : the arbiter's view (it serves the masters, drives the slave port)
//   master : the environment's view (masters plus the slave memory)
// -----------------------------------------------------------------------------
interface soc_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req_i,    m1_req_i,    m2_req_i;
    logic [ADDR_WIDTH-1:0] m0_addr_i,   m1_addr_i,   m2_addr_i;
    logic                  m0_we_i,     m1_we_i,     m2_we_i;
    logic [DATA_WIDTH-1:0] m0_wdata_i,  m1_wdata_i,  m2_wdata_i;
    logic                  m0_gnt_o,    m1_gnt_o,    m2_gnt_o;
    logic                  m0_rvalid_o, m1_rvalid_o, m2_rvalid_o;
    logic [DATA_WIDTH-1:0] m0_rdata_o,  m1_rdata_o,  m2_rdata_o;
    logic                  m0_err_o,    m1_err_o,    m2_err_o;

    logic                  s_req_o;
    logic [ADDR_WIDTH-1:0] s_addr_o;
    logic                  s_we_o;
    logic [DATA_WIDTH-1:0] s_wdata_o;
    logic                  s_gnt_i;
    logic                  s_rvalid_i;
    logic [DATA_WIDTH-1:0] s_rdata_i;

    modport slave (
        input  m0_req_i, m1_req_i, m2_req_i,
        input  m0_addr_i, m1_addr_i, m2_addr_i,
        input  m0_we_i, m1_we_i, m2_we_i,
        input  m0_wdata_i, m1_wdata_i, m2_wdata_i,
        output m0_gnt_o, m1_gnt_o, m2_gnt_o,
        output m0_rvalid_o, m1_rvalid_o, m2_rvalid_o,
        output m0_rdata_o, m1_rdata_o, m2_rdata_o,
        output m0_err_o, m1_err_o, m2_err_o,
        output s_req_o, s_addr_o, s_we_o, s_wdata_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i
    );

    modport master (
        output m0_req_i, m1_req_i, m2_req_i,
        output m0_addr_i, m1_addr_i, m2_addr_i,
        output m0_we_i, m1_we_i, m2_we_i,
        output m0_wdata_i, m1_wdata_i, m2_wdata_i,
        input  m0_gnt_o, m1_gnt_o, m2_gnt_o,
        input  m0_rvalid_o, m1_rvalid_o, m2_rvalid_o,
        input  m0_rdata_o, m1_rdata_o, m2_rdata_o,
        input  m0_err_o, m1_err_o, m2_err_o,
        input  s_req_o, s_addr_o, s_we_o, s_wdata_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i
    );
endinterface

// File: rtl/soc_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// soc_bus_arbiter
// Single-outstanding arbiter sharing one slave memory port between the JTAG
// debug port (m0, fixed top priority), the core data port (m1) and the core
// fetch port (m2); m1/m2 alternate round-robin and are blocked by halt_i.
// A response timeout turns a dead slave into an error completion.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : master request ports and slave port (soc_bus_arbiter_if.slave)
//   halt_i : debug halt, gates new grants to m1/m2 only
//   busy_o : a transaction is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module soc_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    soc_bus_arbiter_if.slave bus,
    input  logic             halt_i,
    output logic             busy_o
);
    localparam int                TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic [1:0] {OWN_M0, OWN_M1, OWN_M2} owner_e;

    state_e                state_q,   state_d;
    owner_e                owner_q,   owner_d;
    logic                  rr_last_q, rr_last_d;   // 1: m2 won last, 0: m1
    logic [TCNT_W-1:0]     tcnt_q,    tcnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  we_q,      we_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

    owner_e                win;
    logic                  win_valid;
    logic [2:0]            gnt_v, rv_v, gnt_out, rv_out;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  s_req;

    function automatic logic [2:0] owner_onehot(owner_e o);
        return 3'b001 << o;
    endfunction

    // Winner selection; only acted upon in IDLE.
    always_comb begin
        win       = OWN_M0;
        win_valid = 1'b0;
        if (bus.m0_req_i) begin
            win       = OWN_M0;
            win_valid = 1'b1;
        end else if (bus.m1_req_i && bus.m2_req_i && !halt_i) begin
            win       = rr_last_q ? OWN_M1 : OWN_M2;
            win_valid = 1'b1;
        end else if (bus.m1_req_i && !halt_i) begin
            win       = OWN_M1;
            win_valid = 1'b1;
        end else if (bus.m2_req_i && !halt_i) begin
            win       = OWN_M2;
            win_valid = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        tcnt_d     = tcnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        gnt_v      = '0;
        rv_v       = '0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        s_req      = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_v   = owner_onehot(win);
                    owner_d = win;
                    tcnt_d  = '0;
                    state_d = REQ;
                    case (win)
                        OWN_M1:  begin addr_d = bus.m1_addr_i; we_d = bus.m1_we_i; wdata_d = bus.m1_wdata_i; end
                        OWN_M2:  begin addr_d = bus.m2_addr_i; we_d = bus.m2_we_i; wdata_d = bus.m2_wdata_i; end
                        default: begin addr_d = bus.m0_addr_i; we_d = bus.m0_we_i; wdata_d = bus.m0_wdata_i; end
                    endcase
                    // Debug accesses do not disturb the m1/m2 fairness pointer.
                    if (win != OWN_M0) rr_last_d = (win == OWN_M2);
                end
            end
            REQ: begin
                s_req = 1'b1;
                // A real handshake takes precedence over a timeout in the same cycle.
                if (bus.s_gnt_i) begin
                    tcnt_d  = '0;
                    state_d = RESP;
                end else if (tcnt_q == TCNT_MAX) begin
                    rv_v     = owner_onehot(owner_q);
                    resp_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;   // never passes TCNT_MAX: that branch leaves the state
                end
            end
            RESP: begin
                if (bus.s_rvalid_i) begin
                    rv_v       = owner_onehot(owner_q);
                    resp_rdata = we_q ? '0 : bus.s_rdata_i;
                    state_d    = IDLE;
                end else if (tcnt_q == TCNT_MAX) begin
                    rv_v     = owner_onehot(owner_q);
                    resp_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_M0;
            rr_last_q <= 1'b1;
            tcnt_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            tcnt_q    <= tcnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    // Pulses are masked while rst is high: the state register discards that
    // cycle, so a grant or response reported then would never be honoured.
    assign gnt_out = rst ? 3'b000 : gnt_v;
    assign rv_out  = rst ? 3'b000 : rv_v;

    assign bus.m0_gnt_o    = gnt_out[0];
    assign bus.m1_gnt_o    = gnt_out[1];
    assign bus.m2_gnt_o    = gnt_out[2];
    assign bus.m0_rvalid_o = rv_out[0];
    assign bus.m1_rvalid_o = rv_out[1];
    assign bus.m2_rvalid_o = rv_out[2];
    assign bus.m0_err_o    = rv_out[0] & resp_err;
    assign bus.m1_err_o    = rv_out[1] & resp_err;
    assign bus.m2_err_o    = rv_out[2] & resp_err;
    assign bus.m0_rdata_o  = rv_out[0] ? resp_rdata : '0;
    assign bus.m1_rdata_o  = rv_out[1] ? resp_rdata : '0;
    assign bus.m2_rdata_o  = rv_out[2] ? resp_rdata : '0;

    // Payload is held outside REQ; s_req_o alone qualifies it.
    assign bus.s_req_o   = s_req & ~rst;
    assign bus.s_addr_o  = addr_q;
    assign bus.s_we_o    = we_q;
    assign bus.s_wdata_o = wdata_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_soc_bus_arbiter.sv
`timescale 1ns/1ps
module tb_soc_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt_i = 1'b0;
    logic busy_o;

    always #5 clk = ~clk;

    soc_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    soc_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .halt_i (halt_i),
        .busy_o (busy_o)
    );

    typedef struct {
        logic [2:0]  req;
        logic        halt, sgnt, srv;
        logic [31:0] srdata;
        logic [2:0]  e_gnt, e_rv;
        logic [31:0] e_rdata;
        logic        e_sreq, e_busy;
        int          e_pm;
    } vec_t;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    vec_t        vecs[$];
    int          exp_gnt_q[$];
    resp_t       exp_resp_q[$];
    logic [31:0] addr_c[3];
    logic [31:0] wdata_c[3];
    logic        we_c[3];
    int          errors = 0;
    int          checks = 0;
    logic        sb_en  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] gnt_vec();
        return {bus.m2_gnt_o, bus.m1_gnt_o, bus.m0_gnt_o};
    endfunction
    function automatic logic [2:0] rv_vec();
        return {bus.m2_rvalid_o, bus.m1_rvalid_o, bus.m0_rvalid_o};
    endfunction
    function automatic logic [2:0] err_vec();
        return {bus.m2_err_o, bus.m1_err_o, bus.m0_err_o};
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        case (m)
            0:       return bus.m0_rdata_o;
            1:       return bus.m1_rdata_o;
            default: return bus.m2_rdata_o;
        endcase
    endfunction

    task automatic add_row(input logic [2:0] req, input logic halt, input logic sgnt, input logic srv,
                           input logic [31:0] srdata, input logic [2:0] e_gnt, input logic [2:0] e_rv,
                           input logic [31:0] e_rdata, input logic e_sreq, input logic e_busy, input int e_pm);
        vec_t v;
        v = '{req, halt, sgnt, srv, srdata, e_gnt, e_rv, e_rdata, e_sreq, e_busy, e_pm};
        vecs.push_back(v);
    endtask

    // One bus cycle: drive just after the rising edge, settle until the falling edge.
    task automatic cyc(input logic [2:0] req, input logic h, input logic sg, input logic sv,
                       input logic [31:0] sd, input logic r);
        @(posedge clk);
        #1;
        rst            = r;
        halt_i         = h;
        bus.m0_req_i   = req[0];
        bus.m1_req_i   = req[1];
        bus.m2_req_i   = req[2];
        bus.s_gnt_i    = sg;
        bus.s_rvalid_i = sv;
        bus.s_rdata_i  = sd;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 128'({gnt_vec(), rv_vec(), err_vec(), bus.s_req_o, bus.s_we_o, busy_o,
                                   bus.s_addr_o, bus.s_wdata_o}), 128'(0));
        check({tag, "_rdata"}, 128'({bus.m2_rdata_o, bus.m1_rdata_o, bus.m0_rdata_o}), 128'(0));
    endtask

    // Scoreboard: every grant / completion pulse must match the oldest expectation.
    always @(negedge clk) begin : sb_monitor
        logic [2:0] g, v;
        resp_t      e;
        int         eg;
        g = gnt_vec();
        v = rv_vec();
        if (sb_en) begin
            for (int m = 0; m < 3; m++) begin
                if (g[m]) begin
                    if (exp_gnt_q.size() == 0) check("sb_gnt_unexpected", 128'(g), 128'(0));
                    else begin
                        eg = exp_gnt_q.pop_front();
                        check("sb_gnt_owner", 128'(m), 128'(eg));
                    end
                end
                if (v[m]) begin
                    if (exp_resp_q.size() == 0) check("sb_resp_unexpected", 128'(v), 128'(0));
                    else begin
                        e = exp_resp_q.pop_front();
                        check("sb_resp", 128'({m, err_vec() >> m & 3'b001, rdata_of(m)}),
                              128'({e.m, 3'(e.err), e.rdata}));
                    end
                end
            end
        end
    end

    initial begin
        logic [95:0] exp_rd;
        resp_t       r;

        addr_c  = '{32'h20, 32'h100, 32'h200};
        wdata_c = '{32'h55, 32'h1111, 32'h2222};
        we_c    = '{1'b1, 1'b0, 1'b0};
        bus.m0_addr_i = addr_c[0]; bus.m0_we_i = we_c[0]; bus.m0_wdata_i = wdata_c[0];
        bus.m1_addr_i = addr_c[1]; bus.m1_we_i = we_c[1]; bus.m1_wdata_i = wdata_c[1];
        bus.m2_addr_i = addr_c[2]; bus.m2_we_i = we_c[2]; bus.m2_wdata_i = wdata_c[2];
        bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.m2_req_i = 1'b0;
        bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0; bus.s_rdata_i = '0;

        //       req    halt  sgnt  srv   srdata        e_gnt   e_rv    e_rdata       sreq  busy  pm
        add_row(3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b111, 1'b0, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b110, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 0);
        add_row(3'b110, 1'b0, 1'b0, 1'b1, 32'h12345678, 3'b000, 3'b001, 32'h0,        1'b0, 1'b1, 0);
        add_row(3'b110, 1'b0, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b110, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 1);
        add_row(3'b110, 1'b0, 1'b0, 1'b1, 32'hA1,       3'b000, 3'b010, 32'hA1,       1'b0, 1'b1, 0);
        add_row(3'b110, 1'b0, 1'b0, 1'b0, 32'h0,        3'b100, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b010, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 2);
        add_row(3'b010, 1'b0, 1'b0, 1'b1, 32'hB2,       3'b000, 3'b100, 32'hB2,       1'b0, 1'b1, 0);
        add_row(3'b010, 1'b0, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b000, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 1);
        add_row(3'b000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 3'b000, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1, 0);
        add_row(3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b110, 1'b1, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b111, 1'b1, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b110, 1'b1, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 0);
        add_row(3'b110, 1'b1, 1'b0, 1'b1, 32'h9999,     3'b000, 3'b001, 32'h0,        1'b0, 1'b1, 0);
        add_row(3'b010, 1'b1, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b010, 1'b0, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 32'h0,        1'b0, 1'b0, 0);
        add_row(3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 1);
        add_row(3'b000, 1'b1, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 1);
        add_row(3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b1, 0);
        add_row(3'b000, 1'b1, 1'b0, 1'b1, 32'hC3,       3'b000, 3'b010, 32'hC3,       1'b0, 1'b1, 0);
        add_row(3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 0);

        // Reset values, both while held and after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all_zero("after_reset");

        // Table: grant order m0,m1,m2,m1, minimum-latency read, halt gating.
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].req, vecs[i].halt, vecs[i].sgnt, vecs[i].srv, vecs[i].srdata, 1'b0);
            exp_rd = '0;
            for (int m = 0; m < 3; m++)
                if (vecs[i].e_rv[m]) exp_rd[m*32 +: 32] = vecs[i].e_rdata;
            check($sformatf("r%0d_gnt", i),   128'(gnt_vec()), 128'(vecs[i].e_gnt));
            check($sformatf("r%0d_rv", i),    128'(rv_vec()),  128'(vecs[i].e_rv));
            check($sformatf("r%0d_err", i),   128'(err_vec()), 128'(0));
            check($sformatf("r%0d_rdata", i), 128'({bus.m2_rdata_o, bus.m1_rdata_o, bus.m0_rdata_o}), 128'(exp_rd));
            check($sformatf("r%0d_sreq", i),  128'(bus.s_req_o), 128'(vecs[i].e_sreq));
            check($sformatf("r%0d_busy", i),  128'(busy_o), 128'(vecs[i].e_busy));
            if (vecs[i].e_sreq)
                check($sformatf("r%0d_payload", i), 128'({bus.s_addr_o, bus.s_we_o, bus.s_wdata_o}),
                      128'({addr_c[vecs[i].e_pm], we_c[vecs[i].e_pm], wdata_c[vecs[i].e_pm]}));
        end

        sb_en = 1'b1;

        // Timeout: m2 granted, slave silent; error completion 4 cycles into REQ.
        exp_gnt_q.push_back(2);
        cyc(3'b100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                r = '{2, 1'b1, 32'h0};
                exp_resp_q.push_back(r);
            end
            cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("to_rv_c%0d", i), 128'(bus.m2_rvalid_o), 128'(i == 5));
            check($sformatf("to_sreq_c%0d", i), 128'(bus.s_req_o), 128'(1));
        end
        check("to_err", 128'({bus.m2_err_o, bus.m2_rdata_o}), 128'({1'b1, 32'h0}));
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 32'hFF, 1'b0);
        check("stray_rvalid", 128'({rv_vec(), busy_o}), 128'(0));

        // Handshakes arriving exactly at the timeout limit win over the timeout.
        exp_gnt_q.push_back(1);
        cyc(3'b010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(3'b000, 1'b0, (i == 5), 1'b0, 32'h0, 1'b0);
            check($sformatf("hs_req_c%0d", i), 128'({bus.m1_rvalid_o, bus.s_req_o}), 128'({1'b0, 1'b1}));
        end
        for (int j = 1; j <= 5; j++) begin
            if (j == 5) begin
                r = '{1, 1'b0, 32'h77};
                exp_resp_q.push_back(r);
            end
            cyc(3'b000, 1'b0, 1'b0, (j == 5), 32'h77, 1'b0);
            check($sformatf("hs_resp_c%0d", j), 128'({bus.m1_rvalid_o, bus.m1_err_o, bus.s_req_o}),
                  128'({(j == 5), 1'b0, 1'b0}));
        end

        // Reset during RESP discards the response and restores rr_last to m2.
        exp_gnt_q.push_back(0);
        cyc(3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("pre_rst_busy", 128'(busy_o), 128'(1));
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 32'hEE, 1'b1);
        check("rst_resp_masked", 128'(rv_vec()), 128'(0));
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all_zero("post_rst");
        exp_gnt_q.push_back(1);
        cyc(3'b110, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("post_rst_tie", 128'(gnt_vec()), 128'(3'b010));
        cyc(3'b100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        r = '{1, 1'b0, 32'h31};
        exp_resp_q.push_back(r);
        cyc(3'b100, 1'b0, 1'b0, 1'b1, 32'h31, 1'b0);
        exp_gnt_q.push_back(2);
        cyc(3'b100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        r = '{2, 1'b0, 32'h42};
        exp_resp_q.push_back(r);
        cyc(3'b000, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
        repeat (2) cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        check("sb_gnt_drained", 128'(exp_gnt_q.size()), 128'(0));
        check("sb_resp_drained", 128'(exp_resp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
